// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory and the CPU fetch stage:
// default geometry and the loader state encoding.
package imem_loader_pkg;

   localparam int unsigned IMEM_DATA_W = 32;
   localparam int unsigned IMEM_DEPTH  = 1024;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_LOAD  = 2'd2
   } imem_state_t;

   // True when a word pointer sits on the last word of a DEPTH-word memory.
   function automatic logic is_last_word(input logic [31:0] ptr, input int unsigned depth);
      return ptr == 32'(depth - 1);
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM with registered read.
// Ports: clk, rst (sync, clears read register only), we/re/addr/wdata
// (one access per cycle, write wins), rdata (holds until the next read).
module imem_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024,
   localparam int unsigned ADR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADR_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage array; contents are initialised by the controller's clear walk.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with post-reset zero fill, a streaming program-load
// port (auto-incrementing write pointer) and a 1-cycle-latency fetch port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_start/load_base     open a load session at a word index (RUN only)
//   load_valid/data/last     load beat stream, load_ready accepts
//   loading, load_count      session status and beats written
//   fetch_req/adr/ready      fetch request handshake
//   fetch_valid/data/err     fetch response (data/err hold between responses)
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DATA_W   = IMEM_DATA_W,
   parameter int unsigned DEPTH    = IMEM_DEPTH,
   parameter bit          BYTE_ADR = 1'b1,
   localparam int unsigned ADR_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADR_W-1:0]  load_base,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              loading,
   output logic [ADR_W:0]    load_count,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_adr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_err
);

   imem_state_t       state, state_nxt;
   logic [ADR_W-1:0]  ptr, ptr_nxt;
   logic [ADR_W:0]    cnt_nxt;

   logic              ram_we, ram_re;
   logic [ADR_W-1:0]  ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   logic [31:0]       adr_word;
   logic              adr_misalign, adr_range;
   logic              fetch_fire, fetch_bad;
   logic [ADR_W-1:0]  fetch_idx;
   logic              ptr_last;

   // Fetch address decode: word index plus alignment / range checks.
   always_comb begin
      adr_word     = BYTE_ADR ? (fetch_adr >> 2) : fetch_adr;
      adr_misalign = BYTE_ADR && (fetch_adr[1:0] != 2'b00);
      adr_range    = (adr_word >> ADR_W) != 32'd0;
      fetch_idx    = adr_word[ADR_W-1:0];
      fetch_bad    = adr_misalign || adr_range;
      fetch_fire   = fetch_req && fetch_ready;
      ptr_last     = is_last_word(32'(ptr), DEPTH);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and RAM port arbitration between clear, load and fetch.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = load_count;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = ptr;
      ram_wdata = '0;

      unique case (state)
         ST_CLEAR: begin
            ram_we  = 1'b1;
            ptr_nxt = ptr + ADR_W'(1);
            if (ptr_last) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // Erroneous requests never touch the RAM.
            if (fetch_fire && !fetch_bad) begin
               ram_re   = 1'b1;
               ram_addr = fetch_idx;
            end
            if (load_start) begin
               state_nxt = ST_LOAD;
               ptr_nxt   = load_base;
               cnt_nxt   = '0;
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               ram_we    = 1'b1;
               ram_wdata = load_data;
               ptr_nxt   = ptr + ADR_W'(1);
               cnt_nxt   = load_count + (ADR_W+1)'(1);
               // No wrap: the top word ends the session.
               if (load_last || ptr_last) begin
                  state_nxt = ST_RUN;
               end
            end
         end
         default: begin
            state_nxt = ST_CLEAR;
         end
      endcase

      if (rst) begin
         ram_we = 1'b0;
         ram_re = 1'b0;
      end
   end

   // Pointer, counters and registered handshake/response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= '0;
         load_count  <= '0;
         fetch_ready <= 1'b0;
         load_ready  <= 1'b0;
         loading     <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         ptr         <= ptr_nxt;
         load_count  <= cnt_nxt;
         fetch_ready <= (state_nxt == ST_RUN);
         load_ready  <= (state_nxt == ST_LOAD);
         loading     <= (state_nxt == ST_LOAD);
         fetch_valid <= fetch_fire;
         if (fetch_fire) begin
            fetch_err <= fetch_bad;
         end
      end
   end

   // Both terms are registers that only change on an accepted fetch, so the
   // response holds between strobes.
   assign fetch_data = fetch_err ? '0 : ram_rdata;

   imem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (DEPTH=16, byte addressing).
module tb_imem_loader;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADR_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              load_start;
   logic [ADR_W-1:0]  load_base;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              loading;
   logic [ADR_W:0]    load_count;
   logic              fetch_req;
   logic [31:0]       fetch_adr;
   logic              fetch_ready;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_data;
   logic              fetch_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] exp_data;
      logic        exp_err;
   } fvec_t;

   fvec_t vec [10];

   imem_loader #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .BYTE_ADR (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .load_base   (load_base),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .loading     (loading),
      .load_count  (load_count),
      .fetch_req   (fetch_req),
      .fetch_adr   (fetch_adr),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
      check({tag, " fetch_data"},  fetch_data,       32'd0);
      check({tag, " fetch_err"},   32'(fetch_err),   32'd0);
      check({tag, " load_ready"},  32'(load_ready),  32'd0);
      check({tag, " loading"},     32'(loading),     32'd0);
      check({tag, " load_count"},  32'(load_count),  32'd0);
      check({tag, " fetch_ready"}, 32'(fetch_ready), 32'd0);
   endtask

   // Release reset and count edges until fetch_ready rises (bounded).
   task automatic release_and_time_clear(input string tag);
      int cyc;
      cyc = 0;
      rst = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (fetch_ready) begin
            cyc = n;
            break;
         end
      end
      check({tag, " clear_cycles"}, 32'(cyc), 32'(DEPTH));
   endtask

   task automatic fetch_one(input string tag, input logic [31:0] adr,
                            input logic [31:0] exp_data, input logic exp_err);
      fetch_req = 1'b1;
      fetch_adr = adr;
      step();
      fetch_req = 1'b0;
      check({tag, " valid"}, 32'(fetch_valid), 32'd1);
      check({tag, " data"},  fetch_data,       exp_data);
      check({tag, " err"},   32'(fetch_err),   32'(exp_err));
   endtask

   initial begin
      int acc;

      rst        = 1'b1;
      load_start = 1'b0;
      load_base  = '0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      fetch_req  = 1'b0;
      fetch_adr  = '0;

      // Reset and zero-fill timing.
      repeat (3) step();
      check_reset_outputs("reset");
      release_and_time_clear("clr0");
      fetch_one("fetch_w5_zero", 32'h14, 32'h0, 1'b0);
      step();
      check("pulse_one_cycle", 32'(fetch_valid), 32'd0);

      // Load session at base 4 with a bubble in the stream.
      load_start = 1'b1;
      load_base  = 4'd4;
      step();
      load_start = 1'b0;
      check("load1 loading",     32'(loading),     32'd1);
      check("load1 load_ready",  32'(load_ready),  32'd1);
      check("load1 fetch_ready", 32'(fetch_ready), 32'd0);
      load_valid = 1'b1; load_data = 32'hA0; step();
      check("load1 count_after_a0", 32'(load_count), 32'd1);
      load_valid = 1'b0; step();
      load_valid = 1'b1; load_data = 32'hA1; step();
      load_last  = 1'b1; load_data = 32'hA2; step();
      load_valid = 1'b0; load_last = 1'b0;
      check("load1 count",       32'(load_count),  32'd3);
      check("load1 done",        32'(loading),     32'd0);
      check("load1 back_to_run", 32'(fetch_ready), 32'd1);
      fetch_one("fetch_0x14", 32'h14, 32'hA1, 1'b0);

      // Fetch accepted together with load_start; session at base 14 hits the top.
      fetch_req  = 1'b1;
      fetch_adr  = 32'h14;
      load_start = 1'b1;
      load_base  = 4'd14;
      step();
      fetch_req  = 1'b0;
      load_start = 1'b0;
      check("start_fetch valid", 32'(fetch_valid), 32'd1);
      check("start_fetch data",  fetch_data,       32'hA1);
      check("start_fetch load",  32'(loading),     32'd1);
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         load_valid = 1'b1;
         load_data  = 32'hB0 + 32'(k);
         if (load_ready) acc++;
         step();
      end
      load_valid = 1'b0;
      check("top accepted",    32'(acc),         32'd2);
      check("top count",       32'(load_count),  32'd2);
      check("top loading",     32'(loading),     32'd0);
      check("top fetch_ready", 32'(fetch_ready), 32'd1);

      // Back-to-back fetch table: loaded words, errors, untouched words.
      vec[0] = '{32'h10, 32'hA0, 1'b0};
      vec[1] = '{32'h14, 32'hA1, 1'b0};
      vec[2] = '{32'h18, 32'hA2, 1'b0};
      vec[3] = '{32'h13, 32'h00, 1'b1};
      vec[4] = '{32'h40, 32'h00, 1'b1};
      vec[5] = '{32'h00, 32'h00, 1'b0};
      vec[6] = '{32'h1C, 32'h00, 1'b0};
      vec[7] = '{32'h0C, 32'h00, 1'b0};
      vec[8] = '{32'h38, 32'hB0, 1'b0};
      vec[9] = '{32'h3C, 32'hB1, 1'b0};
      for (int i = 0; i < 10; i++) begin
         fetch_req = 1'b1;
         fetch_adr = vec[i].adr;
         step();
         check($sformatf("vec%0d valid", i), 32'(fetch_valid), 32'd1);
         check($sformatf("vec%0d data", i),  fetch_data,       vec[i].exp_data);
         check($sformatf("vec%0d err", i),   32'(fetch_err),   32'(vec[i].exp_err));
      end
      fetch_req = 1'b0;
      step();
      check("hold valid", 32'(fetch_valid), 32'd0);
      check("hold data",  fetch_data,       32'hB1);
      fetch_one("err_single", 32'h40, 32'h0, 1'b1);
      step();
      check("hold err",      32'(fetch_err), 32'd1);
      check("hold err data", fetch_data,     32'd0);

      // Reset in the middle of a load session.
      load_start = 1'b1;
      load_base  = 4'd8;
      step();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 32'hC0; step();
      load_data  = 32'hC1; step();
      check("midload loading", 32'(loading), 32'd1);
      load_data = 32'hC2;
      rst       = 1'b1;
      step();
      step();
      load_valid = 1'b0;
      check_reset_outputs("midreset");
      release_and_time_clear("clr1");
      fetch_one("rz_w8",  32'h20, 32'h0, 1'b0);
      fetch_one("rz_w9",  32'h24, 32'h0, 1'b0);
      fetch_one("rz_w4",  32'h10, 32'h0, 1'b0);
      fetch_one("rz_w14", 32'h38, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
